panel_mode_ctrl: RTL and testbench

Front-panel mode sequencer sitting directly upstream of the instruction controller. It generates the 2-bit CPUstate (IDLE/IN/CHECK/RUN) that gates the controller's reset and beat counter. In IN mode it writes switch data into program memory; in CHECK mode it reads memory back for display. While CPUstate is RUN it hands the memory port to the CPU datapath.

---
 rtl/panel_mode_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_panel_mode_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_mode_ctrl.sv
// Front-panel mode sequencer: synchronises the switches, walks the IN/CHECK
// memory sequences and hands the memory port to the CPU in RUN. Build with
// PANEL_VERIFY_EN to add read-after-write verification and verify_err.
module panel_mode_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode_sel,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              btn_step,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        CPUstate,
    output logic              panel_sel,
    output logic [ADDR_W-1:0] panel_addr,
    output logic [DATA_W-1:0] panel_wdata,
    output logic              panel_we,
    output logic              panel_re,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
`ifdef PANEL_VERIFY_EN
    output logic              verify_err,
`endif
    output logic              run_start
);

    localparam int SYNC_W = DATA_W + 3;

    localparam logic [1:0] M_IDLE  = 2'b00;
    localparam logic [1:0] M_IN    = 2'b01;
    localparam logic [1:0] M_CHECK = 2'b10;
    localparam logic [1:0] M_RUN   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_IN_RDY,
        S_IN_WR,
        S_IN_INC,
        S_CHK_RD,
        S_CHK_RDY,
        S_RUN
`ifdef PANEL_VERIFY_EN
        , S_IN_VRD,
        S_IN_VCMP
`endif
    } state_t;

    state_t state_reg, state_next;

    // All asynchronous switch inputs share one shift chain: {mode, data, button}
    logic [SYNC_STAGES-1:0][SYNC_W-1:0] sync_reg;
    logic [SYNC_W-1:0]                  sync_out;
    logic [1:0]                         mode_sync;
    logic [DATA_W-1:0]                  data_sync;
    logic                               btn_sync;
    logic                               btn_prev_reg;
    logic                               step_evt;
    logic                               mode_chg;

    logic [ADDR_W-1:0] panel_addr_reg;
    logic [DATA_W-1:0] panel_wdata_reg;
    logic [ADDR_W-1:0] disp_addr_reg;
    logic [DATA_W-1:0] disp_data_reg;
    logic              run_start_reg;
    logic              enter_in;
    logic              enter_chk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg     <= '0;
            btn_prev_reg <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], {mode_sel, sw_data, btn_step}};
            btn_prev_reg <= btn_sync;
        end
    end

    assign sync_out  = sync_reg[SYNC_STAGES-1];
    assign mode_sync = sync_out[SYNC_W-1 -: 2];
    assign data_sync = sync_out[DATA_W:1];
    assign btn_sync  = sync_out[0];
    assign step_evt  = btn_sync & ~btn_prev_reg;
    assign mode_chg  = (mode_sync != CPUstate);

    function automatic state_t entry_state(input logic [1:0] mode);
        case (mode)
            M_IN:    entry_state = S_IN_RDY;
            M_CHECK: entry_state = S_CHK_RD;
            M_RUN:   entry_state = S_RUN;
            default: entry_state = S_IDLE;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; mode requests are only honoured in the waiting states
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_RUN: begin
                if (mode_chg) state_next = entry_state(mode_sync);
            end
            S_IN_RDY: begin
                if (mode_chg)      state_next = entry_state(mode_sync);
                else if (step_evt) state_next = S_IN_WR;
            end
`ifdef PANEL_VERIFY_EN
            S_IN_WR:   state_next = S_IN_VRD;
            S_IN_VRD:  state_next = S_IN_VCMP;
            S_IN_VCMP: state_next = S_IN_INC;
`else
            S_IN_WR:   state_next = S_IN_INC;
`endif
            S_IN_INC:  state_next = S_IN_RDY;
            S_CHK_RD:  state_next = S_CHK_RDY;
            S_CHK_RDY: begin
                if (mode_chg)      state_next = entry_state(mode_sync);
                else if (step_evt) state_next = S_CHK_RD;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        CPUstate  = M_IDLE;
        panel_we  = 1'b0;
        panel_re  = 1'b0;
        panel_sel = 1'b1;
        case (state_reg)
            S_IN_RDY, S_IN_INC: CPUstate = M_IN;
            S_IN_WR: begin
                CPUstate = M_IN;
                panel_we = 1'b1;
            end
`ifdef PANEL_VERIFY_EN
            S_IN_VRD: begin
                CPUstate = M_IN;
                panel_re = 1'b1;
            end
            S_IN_VCMP: CPUstate = M_IN;
`endif
            S_CHK_RD, S_CHK_RDY: begin
                CPUstate = M_CHECK;
                panel_re = 1'b1;
            end
            S_RUN: begin
                CPUstate  = M_RUN;
                panel_sel = 1'b0;
            end
            default: CPUstate = M_IDLE;
        endcase
    end

    // Mode entry is detected as a transition into an entry state from another mode
    assign enter_in  = (state_next == S_IN_RDY) && (CPUstate != M_IN);
    assign enter_chk = (state_next == S_CHK_RD) && (CPUstate != M_CHECK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            panel_addr_reg  <= '0;
            panel_wdata_reg <= '0;
            disp_addr_reg   <= '0;
            disp_data_reg   <= '0;
            run_start_reg   <= 1'b0;
        end else begin
            run_start_reg <= (state_next == S_RUN) && (state_reg != S_RUN);

            if (enter_in || enter_chk) begin
                panel_addr_reg <= sw_addr;
            end else if (state_reg == S_IN_INC ||
                         (state_reg == S_CHK_RDY && state_next == S_CHK_RD)) begin
                panel_addr_reg <= panel_addr_reg + ADDR_W'(1);
            end

            if (state_reg == S_IN_RDY && state_next == S_IN_WR) begin
                panel_wdata_reg <= data_sync;
            end

            case (state_reg)
                S_IN_WR: begin
                    disp_addr_reg <= panel_addr_reg;
                    disp_data_reg <= panel_wdata_reg;
                end
                S_CHK_RD:  disp_addr_reg <= panel_addr_reg;
                S_CHK_RDY: disp_data_reg <= mem_rdata;
                default: ;
            endcase
        end
    end

`ifdef PANEL_VERIFY_EN
    logic verify_err_reg;

    // Sticky until the operator re-enters IN mode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            verify_err_reg <= 1'b0;
        end else if (enter_in) begin
            verify_err_reg <= 1'b0;
        end else if (state_reg == S_IN_VCMP && mem_rdata != panel_wdata_reg) begin
            verify_err_reg <= 1'b1;
        end
    end

    assign verify_err = verify_err_reg;
`endif

    assign panel_addr  = panel_addr_reg;
    assign panel_wdata = panel_wdata_reg;
    assign disp_addr   = disp_addr_reg;
    assign disp_data   = disp_data_reg;
    assign run_start   = run_start_reg;

endmodule

// File: tb/tb_panel_mode_ctrl.sv
// Directed bench for panel_mode_ctrl: a vector table walks IN/CHECK/RUN, then
// hand sequences cover deferred/simultaneous mode changes and reset mid-write.
module tb_panel_mode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode_sel;
    logic [15:0] sw_addr;
    logic [7:0]  sw_data;
    logic        btn_step;
    logic [7:0]  mem_rdata;
    logic [1:0]  CPUstate;
    logic        panel_sel;
    logic [15:0] panel_addr;
    logic [7:0]  panel_wdata;
    logic        panel_we;
    logic        panel_re;
    logic [15:0] disp_addr;
    logic [7:0]  disp_data;
    logic        run_start;
`ifdef PANEL_VERIFY_EN
    logic        verify_err;
`endif

    panel_mode_ctrl #(.ADDR_W(16), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_sel   (mode_sel),
        .sw_addr    (sw_addr),
        .sw_data    (sw_data),
        .btn_step   (btn_step),
        .mem_rdata  (mem_rdata),
        .CPUstate   (CPUstate),
        .panel_sel  (panel_sel),
        .panel_addr (panel_addr),
        .panel_wdata(panel_wdata),
        .panel_we   (panel_we),
        .panel_re   (panel_re),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
`ifdef PANEL_VERIFY_EN
        .verify_err (verify_err),
`endif
        .run_start  (run_start)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous write, one-cycle registered read
    logic [7:0] mem [0:65535];
    logic       force_zero = 1'b0;
    int         we_total = 0;
    int         rs_total = 0;
    int         re_run_total = 0;

    always @(posedge clk) begin
        if (panel_sel && panel_we) mem[panel_addr] <= panel_wdata;
        if (panel_sel && panel_re) mem_rdata <= force_zero ? 8'h00 : mem[panel_addr];
        if (panel_we) we_total <= we_total + 1;
        if (run_start) rs_total <= rs_total + 1;
        if (panel_re && CPUstate == 2'b11) re_run_total <= re_run_total + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        btn_step = 1'b1;
        cycles(8);
        btn_step = 1'b0;
        cycles(8);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] addr;
        logic [7:0]  data;
        int          presses;
        logic [1:0]  exp_state;
        logic [15:0] exp_paddr;
        logic [15:0] exp_daddr;
        logic [7:0]  exp_ddata;
        logic        exp_sel;
        int          exp_we;
        int          exp_rs;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int we0, rs0, rr0;
        int k;
        vecs[0] = '{2'b01, 16'h0010, 8'hA5, 1, 2'b01, 16'h0011, 16'h0010, 8'hA5, 1'b1, 1, 0};
        vecs[1] = '{2'b00, 16'hFFFF, 8'h00, 1, 2'b00, 16'h0011, 16'h0010, 8'hA5, 1'b1, 0, 0};
        vecs[2] = '{2'b01, 16'hFFFF, 8'h5A, 2, 2'b01, 16'h0001, 16'h0000, 8'h5A, 1'b1, 2, 0};
        vecs[3] = '{2'b00, 16'h0000, 8'h00, 0, 2'b00, 16'h0001, 16'h0000, 8'h5A, 1'b1, 0, 0};
        vecs[4] = '{2'b01, 16'h0011, 8'h3C, 1, 2'b01, 16'h0012, 16'h0011, 8'h3C, 1'b1, 1, 0};
        vecs[5] = '{2'b10, 16'h0010, 8'h00, 0, 2'b10, 16'h0010, 16'h0010, 8'hA5, 1'b1, 0, 0};
        vecs[6] = '{2'b10, 16'h0010, 8'h00, 1, 2'b10, 16'h0011, 16'h0011, 8'h3C, 1'b1, 0, 0};
        vecs[7] = '{2'b10, 16'h0010, 8'h00, 1, 2'b10, 16'h0012, 16'h0012, 8'h00, 1'b1, 0, 0};
        vecs[8] = '{2'b11, 16'h0020, 8'h00, 2, 2'b11, 16'h0012, 16'h0012, 8'h00, 1'b0, 0, 1};
        vecs[9] = '{2'b10, 16'hFFFF, 8'h00, 1, 2'b10, 16'h0000, 16'h0000, 8'h5A, 1'b1, 0, 0};

        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem_rdata = 8'h00;
        rst = 1'b0;
        mode_sel = 2'b00;
        sw_addr = 16'h0000;
        sw_data = 8'h00;
        btn_step = 1'b0;
        cycles(3);
        rst = 1'b1;
        cycles(4);

        check("reset CPUstate", CPUstate, 2'b00);
        check("reset panel_sel", panel_sel, 1'b1);
        check("reset panel_we", panel_we, 1'b0);
        check("reset panel_re", panel_re, 1'b0);
        check("reset panel_addr", panel_addr, 16'h0000);
        check("reset disp_data", disp_data, 8'h00);
        check("reset run_start", run_start, 1'b0);

        for (int i = 0; i < 10; i++) begin
            we0 = we_total;
            rs0 = rs_total;
            rr0 = re_run_total;
            mode_sel = vecs[i].mode;
            sw_addr  = vecs[i].addr;
            sw_data  = vecs[i].data;
            cycles(6);
            for (int p = 0; p < vecs[i].presses; p++) press();
            cycles(6);
            $display("vec %0d: mode=%b addr=%h data=%h presses=%0d -> CPUstate=%b panel_addr=%h disp=%h/%h",
                     i, vecs[i].mode, vecs[i].addr, vecs[i].data, vecs[i].presses,
                     CPUstate, panel_addr, disp_addr, disp_data);
            check($sformatf("vec%0d CPUstate", i), CPUstate, vecs[i].exp_state);
            check($sformatf("vec%0d panel_addr", i), panel_addr, vecs[i].exp_paddr);
            check($sformatf("vec%0d disp_addr", i), disp_addr, vecs[i].exp_daddr);
            check($sformatf("vec%0d disp_data", i), disp_data, vecs[i].exp_ddata);
            check($sformatf("vec%0d panel_sel", i), panel_sel, vecs[i].exp_sel);
            check($sformatf("vec%0d we pulses", i), we_total - we0, vecs[i].exp_we);
            check($sformatf("vec%0d run_start pulses", i), rs_total - rs0, vecs[i].exp_rs);
            check($sformatf("vec%0d re in RUN", i), re_run_total - rr0, 0);
        end
        check("mem[0xFFFF]", mem[16'hFFFF], 8'h5A);

        // Mode change arriving one cycle behind the step: the write must finish first
        mode_sel = 2'b01; sw_addr = 16'h0100; sw_data = 8'h77;
        cycles(6);
        we0 = we_total;
        btn_step = 1'b1;
        cycles(1);
        mode_sel = 2'b00;
        cycles(10);
        btn_step = 1'b0;
        cycles(4);
        $display("deferred: we=%0d mem[0100]=%h panel_addr=%h CPUstate=%b",
                 we_total - we0, mem[16'h0100], panel_addr, CPUstate);
        check("deferred we pulses", we_total - we0, 1);
        check("deferred mem[0x0100]", mem[16'h0100], 8'h77);
        check("deferred panel_addr", panel_addr, 16'h0101);
        check("deferred CPUstate", CPUstate, 2'b00);

        // Step and mode change in the same cycle: mode change wins
        mode_sel = 2'b01; sw_addr = 16'h0200; sw_data = 8'h11;
        cycles(6);
        we0 = we_total;
        btn_step = 1'b1;
        mode_sel = 2'b00;
        cycles(10);
        btn_step = 1'b0;
        cycles(4);
        $display("simultaneous: we=%0d mem[0200]=%h panel_addr=%h CPUstate=%b",
                 we_total - we0, mem[16'h0200], panel_addr, CPUstate);
        check("simul we pulses", we_total - we0, 0);
        check("simul mem[0x0200]", mem[16'h0200], 8'h00);
        check("simul panel_addr", panel_addr, 16'h0200);
        check("simul CPUstate", CPUstate, 2'b00);

        // Reset asserted while panel_we is high clears it without waiting for a clock
        mode_sel = 2'b01; sw_addr = 16'h0300; sw_data = 8'h99;
        cycles(6);
        btn_step = 1'b1;
        k = 0;
        while (k < 20) begin
            @(posedge clk);
            #1;
            if (panel_we) break;
            k++;
        end
        check("midwrite panel_we seen", (k < 20) ? 1 : 0, 1);
        #2;
        rst = 1'b0;
        #1;
        $display("reset mid-write: panel_we=%b CPUstate=%b panel_addr=%h", panel_we, CPUstate, panel_addr);
        check("midwrite panel_we", panel_we, 1'b0);
        check("midwrite CPUstate", CPUstate, 2'b00);
        check("midwrite panel_addr", panel_addr, 16'h0000);
        btn_step = 1'b0;
        mode_sel = 2'b00;
        cycles(3);
        rst = 1'b1;
        cycles(3);

`ifdef PANEL_VERIFY_EN
        force_zero = 1'b1;
        mode_sel = 2'b01; sw_addr = 16'h0400; sw_data = 8'h55;
        cycles(6);
        press();
        $display("verify bad read: verify_err=%b", verify_err);
        check("verify_err set", verify_err, 1'b1);
        force_zero = 1'b0;
        press();
        check("verify_err sticky", verify_err, 1'b1);
        mode_sel = 2'b00;
        cycles(6);
        check("verify_err held in IDLE", verify_err, 1'b1);
        mode_sel = 2'b01;
        cycles(6);
        $display("verify re-entry: verify_err=%b", verify_err);
        check("verify_err cleared", verify_err, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
